// File: rtl/bnn_layer_scheduler_if.sv
// Handshake and bus bundle for bnn_layer_scheduler: host/stream/memory/datapath/result signals.
// The slave modport is the scheduler side and the master modport is the environment side.
interface bnn_layer_scheduler_if #(
    parameter int OUT_DIM = 4,
    parameter int IN_DIM  = 8,
    parameter int CH_CNT  = 8,
    parameter int BIT_CNT = 8,
    parameter int ACC_W   = 16,
    parameter int TILE_W  = 6
);
    logic                       start_i;
    logic [TILE_W-1:0]          cfg_tiles_i;
    logic                       busy_o;
    logic                       done_o;
    logic                       act_valid_i;
    logic                       act_ready_o;
    logic [IN_DIM*CH_CNT-1:0]   act_data_i;
    logic                       wt_en_o;
    logic [TILE_W-1:0]          wt_addr_o;
    logic [OUT_DIM*IN_DIM-1:0]  wt_data_i;
    logic [IN_DIM*CH_CNT-1:0]   dp_act_o;
    logic [OUT_DIM*IN_DIM-1:0]  dp_wt_o;
    logic [OUT_DIM*BIT_CNT-1:0] dp_val_i;
    logic                       res_valid_o;
    logic                       res_ready_i;
    logic [OUT_DIM*ACC_W-1:0]   res_data_o;
    logic                       ovf_o;

    modport slave (
        input  start_i, cfg_tiles_i, act_valid_i, act_data_i, wt_data_i, dp_val_i, res_ready_i,
        output busy_o, done_o, act_ready_o, wt_en_o, wt_addr_o, dp_act_o, dp_wt_o,
               res_valid_o, res_data_o, ovf_o
    );

    modport master (
        output start_i, cfg_tiles_i, act_valid_i, act_data_i, wt_data_i, dp_val_i, res_ready_i,
        input  busy_o, done_o, act_ready_o, wt_en_o, wt_addr_o, dp_act_o, dp_wt_o,
               res_valid_o, res_data_o, ovf_o
    );
endinterface

// File: rtl/bnn_layer_scheduler.sv
// BNN layer scheduler: streams activation tiles, fetches weights, accumulates datapath results per output.
// Optional macro BNN_ACC_SAT_EN: saturating accumulation with sticky ovf_o (default build wraps, ovf_o = 0).
module bnn_layer_scheduler #(
    parameter int OUT_DIM = 4,
    parameter int IN_DIM  = 8,
    parameter int CH_CNT  = 8,
    parameter int BIT_CNT = 8,
    parameter int ACC_W   = 16,
    parameter int TILE_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bnn_layer_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, ACC, OUT} state_e;

`ifdef BNN_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_e                    state_q, state_d;
    logic [TILE_W-1:0]         tiles_q, tiles_d;
    logic [TILE_W-1:0]         idx_q, idx_d;
    logic [IN_DIM*CH_CNT-1:0]  act_q;
    logic [IN_DIM*CH_CNT-1:0]  dp_act_q;
    logic [OUT_DIM*IN_DIM-1:0] dp_wt_q;
    logic signed [ACC_W-1:0]   acc_q [OUT_DIM];
    logic signed [ACC_W-1:0]   acc_d [OUT_DIM];
    logic                      done_q, done_d;
    logic                      ovf_q, ovf_d;
    logic                      start_ok, start_nil, act_hs, last_tile;

    assign start_ok  = (state_q == IDLE) && bus.start_i && (bus.cfg_tiles_i != '0);
    assign start_nil = (state_q == IDLE) && bus.start_i && (bus.cfg_tiles_i == '0);
    assign act_hs    = (state_q == LOAD) && bus.act_valid_i;
    assign last_tile = (idx_q == tiles_q - TILE_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = LOAD;
            LOAD:    if (bus.act_valid_i) state_d = FETCH;
            FETCH:   state_d = ACC;
            ACC:     state_d = last_tile ? OUT : LOAD;
            OUT:     if (bus.res_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o      = (state_q != IDLE);
        bus.act_ready_o = (state_q == LOAD);
        bus.wt_en_o     = act_hs;
        bus.res_valid_o = (state_q == OUT);
        bus.done_o      = done_q || ((state_q == OUT) && bus.res_ready_i);
        bus.wt_addr_o   = idx_q;
        bus.dp_act_o    = dp_act_q;
        bus.dp_wt_o     = dp_wt_q;
        bus.ovf_o       = ovf_q;
        bus.res_data_o  = '0;
        for (int unsigned o = 0; o < OUT_DIM; o++) bus.res_data_o[o*ACC_W +: ACC_W] = acc_q[o];
    end

    // Tile 0 loads the accumulator so no explicit clear is needed between passes.
    always_comb begin
        logic signed [ACC_W-1:0] ext;
        logic signed [ACC_W-1:0] base;
`ifdef BNN_ACC_SAT_EN
        logic signed [ACC_W:0]   wide;
        wide = '0;
`endif
        ext     = '0;
        base    = '0;
        tiles_d = tiles_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        done_d  = start_nil;
        for (int unsigned o = 0; o < OUT_DIM; o++) acc_d[o] = acc_q[o];
        if (start_ok) begin
            tiles_d = bus.cfg_tiles_i;
            idx_d   = '0;
            ovf_d   = 1'b0;
        end
        if (state_q == ACC) begin
            idx_d = idx_q + TILE_W'(1);
            for (int unsigned o = 0; o < OUT_DIM; o++) begin
                ext  = ACC_W'(signed'(bus.dp_val_i[o*BIT_CNT +: BIT_CNT]));
                base = (idx_q == '0) ? '0 : acc_q[o];
`ifdef BNN_ACC_SAT_EN
                wide = (ACC_W+1)'(base) + (ACC_W+1)'(ext);
                if (wide[ACC_W] != wide[ACC_W-1]) begin
                    acc_d[o] = wide[ACC_W] ? ACC_MIN : ACC_MAX;
                    ovf_d    = 1'b1;
                end else begin
                    acc_d[o] = wide[ACC_W-1:0];
                end
`else
                acc_d[o] = base + ext;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tiles_q  <= '0;
            idx_q    <= '0;
            act_q    <= '0;
            dp_act_q <= '0;
            dp_wt_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            for (int unsigned o = 0; o < OUT_DIM; o++) acc_q[o] <= '0;
        end else begin
            tiles_q <= tiles_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            if (act_hs) act_q <= bus.act_data_i;
            // Datapath drive is captured on entry to ACC and then held until the next tile.
            if (state_q == FETCH) begin
                dp_act_q <= act_q;
                dp_wt_q  <= bus.wt_data_i;
            end
            for (int unsigned o = 0; o < OUT_DIM; o++) acc_q[o] <= acc_d[o];
        end
    end

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Directed self-checking bench for bnn_layer_scheduler: main instance (ACC_W=16) plus a narrow
// ACC_W=8 instance for the overflow behaviour selected by BNN_ACC_SAT_EN.
module tb_bnn_layer_scheduler;
    localparam int OD = 4;
    localparam int ID = 8;
    localparam int CC = 8;
    localparam int BC = 8;
    localparam int AW = 16;
    localparam int TW = 6;

`ifdef BNN_ACC_SAT_EN
    localparam int EXP8 = 127;
    localparam bit EXPOVF8 = 1'b1;
`else
    localparam int EXP8 = -56;
    localparam bit EXPOVF8 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_layer_scheduler_if #(.OUT_DIM(OD), .IN_DIM(ID), .CH_CNT(CC), .BIT_CNT(BC),
                             .ACC_W(AW), .TILE_W(TW)) bus ();
    bnn_layer_scheduler_if #(.OUT_DIM(OD), .IN_DIM(ID), .CH_CNT(CC), .BIT_CNT(BC),
                             .ACC_W(8), .TILE_W(TW)) bus8 ();

    bnn_layer_scheduler #(.OUT_DIM(OD), .IN_DIM(ID), .CH_CNT(CC), .BIT_CNT(BC),
                          .ACC_W(AW), .TILE_W(TW)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    bnn_layer_scheduler #(.OUT_DIM(OD), .IN_DIM(ID), .CH_CNT(CC), .BIT_CNT(BC),
                          .ACC_W(8), .TILE_W(TW)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_cmp = 0;
    int n_bad = 0;
    int vtab [16];
    int off = 0;
    int wt_log [$];
    int rv_cnt = 0;

    // Weight word for tile t: every output row holds A0+t.
    function automatic logic [OD*ID-1:0] wpat(input int t);
        logic [ID-1:0] b;
        b = ID'(32'hA0 + t);
        return {OD{b}};
    endfunction

    always @(posedge clk) if (bus.wt_en_o) bus.wt_data_i <= wpat(int'(bus.wt_addr_o));

    // Datapath stand-in: value only correct when activation tag and weight word agree.
    always_comb begin
        int tag;
        tag = int'(bus.dp_act_o[3:0]);
        bus.dp_val_i = '0;
        for (int o = 0; o < OD; o++) begin
            if (bus.dp_wt_o == wpat(tag)) bus.dp_val_i[o*BC +: BC] = BC'(vtab[tag] + o * off);
            else                          bus.dp_val_i[o*BC +: BC] = 8'd50;
        end
    end

    assign bus8.dp_val_i  = {OD{8'd100}};
    assign bus8.wt_data_i = '0;

    always begin
        @(negedge clk);
        #1;
        if (bus.wt_en_o) wt_log.push_back(int'(bus.wt_addr_o));
        if (bus.res_valid_o) rv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_pass(input int n);
        bus.start_i = 1'b1;
        bus.cfg_tiles_i = TW'(n);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic feed_tiles(input int n, input int gap);
        for (int t = 0; t < n; t++) begin
            repeat (gap) @(negedge clk);
            bus.act_valid_i = 1'b1;
            bus.act_data_i = (ID*CC)'(t);
            for (int k = 0; k < 40 && !bus.act_ready_o; k++) @(negedge clk);
            if (!bus.act_ready_o) begin
                n_cmp++; n_bad++;
                $display("FAIL act_ready_timeout: got 0 want 1 (tile %0d)", t);
            end
            @(negedge clk);
            bus.act_valid_i = 1'b0;
        end
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (bus.res_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic handshake(output bit done_hs, output bit busy_after, output bit done_after);
        bus.res_ready_i = 1'b1;
        #1 done_hs = bus.done_o;
        @(negedge clk);
        bus.res_ready_i = 1'b0;
        #1;
        busy_after = bus.busy_o;
        done_after = bus.done_o;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy_o, bus.done_o, bus.act_ready_o, bus.wt_en_o, bus.res_valid_o, bus.ovf_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.busy_o, bus.done_o, bus.act_ready_o,
                     bus.wt_en_o, bus.res_valid_o, bus.ovf_o});
        end
        n_cmp++;
        if (bus.res_data_o !== '0) begin n_bad++; $display("FAIL reset_res_data: got %h want 0", bus.res_data_o); end
        n_cmp++;
        if (bus.dp_act_o !== '0 || bus.dp_wt_o !== '0) begin
            n_bad++; $display("FAIL reset_dp: got act %h wt %h want 0", bus.dp_act_o, bus.dp_wt_o);
        end
        n_cmp++;
        if (bus.wt_addr_o !== '0) begin n_bad++; $display("FAIL reset_wt_addr: got %0d want 0", bus.wt_addr_o); end
    endtask

    task automatic test_three_tiles();
        bit ok, d, b, dd;
        int exp [OD] = '{10, 10, 10, 10};
        logic signed [AW-1:0] r;
        vtab[0] = 5; vtab[1] = -2; vtab[2] = 7; off = 0;
        @(negedge clk);
        wt_log.delete();
        start_pass(3);
        n_cmp++;
        if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL three_busy: got %b want 1", bus.busy_o); end
        feed_tiles(3, 0);
        wait_res(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL three_res_valid: got 0 want 1"); end
        for (int o = 0; o < OD; o++) begin
            r = bus.res_data_o[o*AW +: AW];
            n_cmp++;
            if (int'(r) !== exp[o]) begin n_bad++; $display("FAIL three_sum[%0d]: got %0d want %0d", o, r, exp[o]); end
        end
        n_cmp++;
        if ({bus.done_o, bus.ovf_o, bus.act_ready_o} !== 3'b000) begin
            n_bad++; $display("FAIL three_out_flags: got %b want 000", {bus.done_o, bus.ovf_o, bus.act_ready_o});
        end
        handshake(d, b, dd);
        n_cmp++;
        if (d !== 1'b1) begin n_bad++; $display("FAIL three_done_on_hs: got %b want 1", d); end
        n_cmp++;
        if ({b, dd} !== 2'b00) begin n_bad++; $display("FAIL three_after_hs: got busy %b done %b want 0 0", b, dd); end
        n_cmp++;
        if (wt_log.size() !== 3) begin n_bad++; $display("FAIL three_wt_count: got %0d want 3", wt_log.size()); end
    endtask

    task automatic test_zero_tiles();
        @(negedge clk);
        wt_log.delete();
        rv_cnt = 0;
        start_pass(0);
        #1;
        n_cmp++;
        if ({bus.done_o, bus.busy_o} !== 2'b10) begin
            n_bad++; $display("FAIL zero_done_pulse: got done %b busy %b want 1 0", bus.done_o, bus.busy_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL zero_done_width: got %b want 0", bus.done_o); end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rv_cnt !== 0 || wt_log.size() !== 0) begin
            n_bad++; $display("FAIL zero_no_activity: got res_valid %0d wt_en %0d want 0 0", rv_cnt, wt_log.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok, d, b, dd;
        int exp [OD] = '{7, 9, 11, 13};
        logic signed [AW-1:0] r;
        vtab[0] = 3; vtab[1] = 4; off = 1;
        @(negedge clk);
        start_pass(2);
        bus.start_i = 1'b1;
        bus.cfg_tiles_i = TW'(5);
        feed_tiles(2, 0);
        wait_res(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_res_valid: got 0 want 1"); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.res_valid_o !== 1'b1 || bus.done_o !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold_valid: got valid %b done %b want 1 0 (cycle %0d)",
                                  bus.res_valid_o, bus.done_o, k);
            end
            for (int o = 0; o < OD; o++) begin
                r = bus.res_data_o[o*AW +: AW];
                n_cmp++;
                if (int'(r) !== exp[o]) begin
                    n_bad++; $display("FAIL bp_hold_data[%0d]: got %0d want %0d (cycle %0d)", o, r, exp[o], k);
                end
            end
        end
        bus.start_i = 1'b0;
        handshake(d, b, dd);
        n_cmp++;
        if ({d, b, dd} !== 3'b100) begin
            n_bad++; $display("FAIL bp_handshake: got done %b busy %b done_after %b want 1 0 0", d, b, dd);
        end
    endtask

    task automatic test_sat();
        logic signed [7:0] r;
        @(negedge clk);
        bus8.start_i = 1'b1;
        bus8.cfg_tiles_i = TW'(2);
        @(negedge clk);
        bus8.start_i = 1'b0;
        for (int t = 0; t < 2; t++) begin
            bus8.act_valid_i = 1'b1;
            for (int k = 0; k < 40 && !bus8.act_ready_o; k++) @(negedge clk);
            @(negedge clk);
            bus8.act_valid_i = 1'b0;
        end
        for (int k = 0; k < 40 && !bus8.res_valid_o; k++) @(negedge clk);
        n_cmp++;
        if (bus8.res_valid_o !== 1'b1) begin n_bad++; $display("FAIL ovf_res_valid: got 0 want 1"); end
        for (int o = 0; o < OD; o++) begin
            r = bus8.res_data_o[o*8 +: 8];
            n_cmp++;
            if (int'(r) !== EXP8) begin n_bad++; $display("FAIL ovf_sum[%0d]: got %0d want %0d", o, r, EXP8); end
        end
        n_cmp++;
        if (bus8.ovf_o !== EXPOVF8) begin n_bad++; $display("FAIL ovf_flag: got %b want %b", bus8.ovf_o, EXPOVF8); end
        bus8.res_ready_i = 1'b1;
        @(negedge clk);
        bus8.res_ready_i = 1'b0;
        n_cmp++;
        if (bus8.ovf_o !== EXPOVF8) begin n_bad++; $display("FAIL ovf_sticky: got %b want %b", bus8.ovf_o, EXPOVF8); end
        bus8.start_i = 1'b1;
        bus8.cfg_tiles_i = TW'(1);
        @(negedge clk);
        bus8.start_i = 1'b0;
        n_cmp++;
        if (bus8.ovf_o !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_on_start: got %b want 0", bus8.ovf_o); end
        bus8.act_valid_i = 1'b1;
        @(negedge clk);
        bus8.act_valid_i = 1'b0;
        for (int k = 0; k < 40 && !bus8.res_valid_o; k++) @(negedge clk);
        r = bus8.res_data_o[7:0];
        n_cmp++;
        if (int'(r) !== 100 || bus8.ovf_o !== 1'b0) begin
            n_bad++; $display("FAIL ovf_single_tile: got %0d ovf %b want 100 ovf 0", r, bus8.ovf_o);
        end
        bus8.res_ready_i = 1'b1;
        @(negedge clk);
        bus8.res_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok, d, b, dd;
        int exp [OD] = '{10, 18, 26, 34};
        logic signed [AW-1:0] r;
        vtab[0] = 1; vtab[1] = 2; vtab[2] = 3; vtab[3] = 4; off = 2;
        @(negedge clk);
        start_pass(4);
        feed_tiles(2, 0);
        bus.act_valid_i = 1'b1;
        bus.act_data_i = (ID*CC)'(2);
        for (int k = 0; k < 40 && !bus.act_ready_o; k++) @(negedge clk);
        @(negedge clk);
        bus.act_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy_o, bus.act_ready_o, bus.res_valid_o, bus.done_o} !== 4'b0) begin
            n_bad++; $display("FAIL midrst_ctrl: got %b want 0000",
                              {bus.busy_o, bus.act_ready_o, bus.res_valid_o, bus.done_o});
        end
        n_cmp++;
        if (bus.res_data_o !== '0 || bus.dp_act_o !== '0 || bus.dp_wt_o !== '0) begin
            n_bad++; $display("FAIL midrst_data: got res %h act %h wt %h want 0", bus.res_data_o,
                              bus.dp_act_o, bus.dp_wt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rv_cnt = 0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (rv_cnt !== 0 || bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL midrst_needs_start: got res_valid %0d busy %b want 0 0", rv_cnt, bus.busy_o);
        end
        start_pass(4);
        feed_tiles(4, 0);
        wait_res(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL midrst_res_valid: got 0 want 1"); end
        for (int o = 0; o < OD; o++) begin
            r = bus.res_data_o[o*AW +: AW];
            n_cmp++;
            if (int'(r) !== exp[o]) begin n_bad++; $display("FAIL midrst_sum[%0d]: got %0d want %0d", o, r, exp[o]); end
        end
        handshake(d, b, dd);
        n_cmp++;
        if ({d, b} !== 2'b10) begin n_bad++; $display("FAIL midrst_handshake: got done %b busy %b want 1 0", d, b); end
    endtask

    task automatic test_gapped();
        bit ok, d, b, dd;
        int exp [OD] = '{13, 16, 19, 22};
        logic signed [AW-1:0] r;
        vtab[0] = -8; vtab[1] = 20; vtab[2] = 1; off = 1;
        @(negedge clk);
        wt_log.delete();
        start_pass(3);
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({bus.busy_o, bus.act_ready_o, bus.wt_en_o} !== 3'b110) begin
            n_bad++; $display("FAIL gap_load_hold: got %b want 110", {bus.busy_o, bus.act_ready_o, bus.wt_en_o});
        end
        feed_tiles(3, 4);
        wait_res(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL gap_res_valid: got 0 want 1"); end
        for (int o = 0; o < OD; o++) begin
            r = bus.res_data_o[o*AW +: AW];
            n_cmp++;
            if (int'(r) !== exp[o]) begin n_bad++; $display("FAIL gap_sum[%0d]: got %0d want %0d", o, r, exp[o]); end
        end
        handshake(d, b, dd);
        n_cmp++;
        if (wt_log.size() !== 3) begin
            n_bad++; $display("FAIL gap_wt_count: got %0d want 3", wt_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wt_log[i] !== i) begin n_bad++; $display("FAIL gap_wt_addr[%0d]: got %0d want %0d", i, wt_log[i], i); end
            end
        end
    endtask

    initial begin
        bus.start_i = 1'b0;  bus.cfg_tiles_i = '0; bus.act_valid_i = 1'b0;
        bus.act_data_i = '0; bus.res_ready_i = 1'b0;
        bus8.start_i = 1'b0; bus8.cfg_tiles_i = '0; bus8.act_valid_i = 1'b0;
        bus8.act_data_i = '0; bus8.res_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) vtab[i] = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_three_tiles();
        test_zero_tiles();
        test_backpressure();
        test_sat();
        test_reset_mid();
        test_gapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
